// File: rtl/multi_switch_debouncer.sv
// Purpose : N-channel switch debouncer with press/release pulses and auto-repeat on KEY_UP.
// Latency : KEY_EN/KEY_PRESS/KEY_REL/KEY_UP registered on the CE/REP_CE edge that decides them.
// Backpr. : none; free-running strobes, every event is a single-cycle pulse that is never held.
//
// Ports:
//   CLK, CLR_N   clock (rising edge) and asynchronous active-low reset
//   CE           sampling strobe; REP_CE repeat time-base strobe
//   S_IN         raw switches (1 = pressed), already synchronised to CLK
//   KEY_EN       debounced state; KEY_PRESS / KEY_REL edge pulses
//   KEY_UP       press pulse OR auto-repeat pulse; ANY_EN = OR of KEY_EN
//
// Build option: define REPEAT_ACCEL_EN to switch to REPEAT_FAST_PERIOD after ACCEL_AFTER
// repeats of a continuous hold. Without it every repeat reload uses REPEAT_PERIOD.

module multi_switch_debouncer #(
  parameter int CH_NUM             = 4,
  parameter int BITS_NUM           = 4,
  parameter int REPEAT_START_DELAY = 99,
  parameter int REPEAT_PERIOD      = 20,
  parameter int REPEAT_FAST_PERIOD = 5,
  parameter int ACCEL_AFTER        = 8
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              CE,
  input  logic              REP_CE,
  input  logic [CH_NUM-1:0] S_IN,
  output logic [CH_NUM-1:0] KEY_EN,
  output logic [CH_NUM-1:0] KEY_PRESS,
  output logic [CH_NUM-1:0] KEY_REL,
  output logic [CH_NUM-1:0] KEY_UP,
  output logic              ANY_EN
);

  localparam int MAX_AB  = (REPEAT_START_DELAY > REPEAT_PERIOD) ? REPEAT_START_DELAY : REPEAT_PERIOD;
  localparam int CNT_MAX = (MAX_AB > REPEAT_FAST_PERIOD) ? MAX_AB : REPEAT_FAST_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] START_LD  = CNT_W'(REPEAT_START_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);
`ifdef REPEAT_ACCEL_EN
  localparam logic [CNT_W-1:0] FAST_LD   = CNT_W'(REPEAT_FAST_PERIOD - 1);
  localparam int               TALLY_W   = (ACCEL_AFTER > 0) ? $clog2(ACCEL_AFTER + 1) : 1;
  localparam logic [TALLY_W-1:0] TALLY_SAT = TALLY_W'(ACCEL_AFTER);
`endif

  // Elaboration-time parameter sanity checks.
  if (BITS_NUM < 2) begin : g_bad_bits
    $error("BITS_NUM must be >= 2");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_FAST_PERIOD < 1) begin : g_bad_period
    $error("repeat periods must be >= 1");
  end
  if (REPEAT_START_DELAY < 0 || ACCEL_AFTER < 0) begin : g_bad_delay
    $error("REPEAT_START_DELAY and ACCEL_AFTER must be >= 0");
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [BITS_NUM-1:0] sh;
    logic [BITS_NUM-1:0] sh_nxt;
    logic [CNT_W-1:0]    rcnt;
    logic [CNT_W-1:0]    reload;
    logic                en_q;
    logic                press_q;
    logic                rel_q;
    logic                up_q;
    logic                rise;
    logic                fall;
    logic                rep_hit;
`ifdef REPEAT_ACCEL_EN
    logic [TALLY_W-1:0]  tally;
    logic [TALLY_W-1:0]  tally_nxt;
`endif

    always_comb begin
      sh_nxt  = {sh[BITS_NUM-2:0], S_IN[i]};
      // Hysteresis: only a full run of identical samples changes the state.
      rise    = CE && !en_q && (&sh_nxt);
      fall    = CE &&  en_q && !(|sh_nxt);
      // A release on the same edge as an expiring repeat suppresses the repeat.
      rep_hit = en_q && REP_CE && (rcnt == '0) && !fall;
`ifdef REPEAT_ACCEL_EN
      tally_nxt = (tally == TALLY_SAT) ? tally : tally + 1'b1;
      // The repeat that brings the tally to its limit already schedules the fast period.
      reload    = (tally_nxt == TALLY_SAT) ? FAST_LD : PERIOD_LD;
`else
      reload    = PERIOD_LD;
`endif
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
        sh      <= '0;
        en_q    <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        up_q    <= 1'b0;
        rcnt    <= START_LD;
      end else begin
        if (CE) begin
          sh <= sh_nxt;
        end
        if (rise) begin
          en_q <= 1'b1;
        end else if (fall) begin
          en_q <= 1'b0;
        end
        press_q <= rise;
        rel_q   <= fall;
        // rise needs en_q=0 and rep_hit needs en_q=1, so they never overlap.
        up_q    <= rise | rep_hit;
        // While released (and on the release edge) the counter sits at the start
        // delay, so the press edge always begins from a fresh load.
        if (!en_q || fall) begin
          rcnt <= START_LD;
        end else if (REP_CE) begin
          rcnt <= (rcnt == '0) ? reload : rcnt - 1'b1;
        end
      end
    end

`ifdef REPEAT_ACCEL_EN
    always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
        tally <= '0;
      end else if (!en_q || fall) begin
        tally <= '0;
      end else if (rep_hit) begin
        tally <= tally_nxt;
      end
    end
`endif

    assign KEY_EN[i]    = en_q;
    assign KEY_PRESS[i] = press_q;
    assign KEY_REL[i]   = rel_q;
    assign KEY_UP[i]    = up_q;
  end

  assign ANY_EN = |KEY_EN;

endmodule

// File: tb/tb_multi_switch_debouncer.sv
module tb_multi_switch_debouncer;

  localparam int CH    = 4;
  localparam int START = 99;
  localparam int PER   = 20;
  localparam int FAST  = 5;
  localparam int ACC   = 8;

  logic          CLK    = 1'b0;
  logic          CLR_N  = 1'b1;
  logic          CE     = 1'b0;
  logic          REP_CE = 1'b0;
  logic [CH-1:0] S_IN   = '0;
  logic [CH-1:0] KEY_EN, KEY_PRESS, KEY_REL, KEY_UP;
  logic          ANY_EN;

  multi_switch_debouncer #(
    .CH_NUM(CH), .BITS_NUM(4), .REPEAT_START_DELAY(START),
    .REPEAT_PERIOD(PER), .REPEAT_FAST_PERIOD(FAST), .ACCEL_AFTER(ACC)
  ) dut (
    .CLK(CLK), .CLR_N(CLR_N), .CE(CE), .REP_CE(REP_CE), .S_IN(S_IN),
    .KEY_EN(KEY_EN), .KEY_PRESS(KEY_PRESS), .KEY_REL(KEY_REL),
    .KEY_UP(KEY_UP), .ANY_EN(ANY_EN)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int            at;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [CH-1:0] up;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int at, input logic [CH-1:0] p,
                            input logic [CH-1:0] r, input logic [CH-1:0] u);
    exp_t e;
    e.at = at; e.press = p; e.rel = r; e.up = u;
    sb.push_back(e);
  endtask

  // Pulse monitor: every pulse must match a scoreboard entry for this cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].at < cyc) begin
      chk("missed_event_cycle", cyc, sb[0].at);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      chk("key_press", KEY_PRESS, e.press);
      chk("key_rel",   KEY_REL,   e.rel);
      chk("key_up",    KEY_UP,    e.up);
    end else if (|{KEY_PRESS, KEY_REL, KEY_UP}) begin
      chk("spurious_pulse", {KEY_PRESS, KEY_REL, KEY_UP}, 0);
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the next rising edge.
  task automatic step(input logic ce, input logic rep, input logic [CH-1:0] s);
    CE = ce; REP_CE = rep; S_IN = s;
    @(posedge CLK); #1;
  endtask

  // REP_CE tick index (counted after the press edge) of the n-th auto-repeat.
  function automatic int repeat_tick(input int n);
`ifdef REPEAT_ACCEL_EN
    if (n > ACC) return START + 1 + (ACC - 1) * PER + (n - ACC) * FAST;
`endif
    return START + 1 + (n - 1) * PER;
  endfunction

  // Press channel ch, hold it with REP_CE every 10 cycles, and release it so the
  // release edge lands on the REP_CE tick of repeat number rel_after.
  task automatic hold_and_release(input int ch, input int rel_after);
    logic [CH-1:0] m;
    int   p, k, nrep, rel_tick;
    logic held, rep;
    m = CH'(1) << ch;
    // Align so the press edge coincides with a REP_CE tick (that tick is ignored).
    while (cyc % 10 != 7) step(1'b1, (cyc % 10 == 0), '0);
    p = cyc + 4;
    expect_evt(p, m, '0, m);
    k = 0; nrep = 1; held = 1'b1;
    rel_tick = repeat_tick(rel_after);
    while (k < rel_tick + 5) begin
      rep = (cyc % 10 == 0);
      if (rep && cyc >= p) begin
        k++;
        if (k == 50) begin
          chk("en_held", KEY_EN, m);
          chk("any_en_held", ANY_EN, 1);
        end
        if (k == rel_tick) begin
          expect_evt(cyc + 1, '0, m, '0);
        end else if (k == repeat_tick(nrep)) begin
          expect_evt(cyc + 1, '0, '0, m);
          nrep++;
        end
      end
      if (cyc % 10 == 7 && k + 1 == rel_tick) held = 1'b0;
      step(1'b1, rep, held ? m : '0);
    end
    chk("en_after_rel", KEY_EN, 0);
    chk("any_en_after_rel", ANY_EN, 0);
  endtask

  initial begin
    logic [5:0] bounce;
    int d;
    bounce = 6'b101101; // applied MSB first: 1,0,1,1,0,1

    // Reset state
    #1 CLR_N = 1'b0;
    #1;
    chk("rst_key_en", KEY_EN, 0);
    chk("rst_pulses", {KEY_PRESS, KEY_REL, KEY_UP}, 0);
    chk("rst_any_en", ANY_EN, 0);
    repeat (3) @(posedge CLK);
    #1 CLR_N = 1'b1;
    repeat (4) step(1'b1, 1'b0, '0);

    // Bounce on channel 1 never reaches a stable press
    for (int i = 5; i >= 0; i--) step(1'b1, 1'b0, CH'(bounce[i]) << 1);
    repeat (6) step(1'b1, 1'b0, '0);
    chk("bounce_key_en", KEY_EN, 0);

    // Press/hold/repeat on channel 0; release coincides with an expiring repeat
`ifdef REPEAT_ACCEL_EN
    hold_and_release(0, 10);
`else
    hold_and_release(0, 3);
`endif
    repeat (30) step(1'b1, (cyc % 10 == 0), '0);
    // Re-press: repeat spacing starts over from the slow period
    hold_and_release(0, 2);

    // Reset in the middle of a hold on channels 2 and 3
    d = cyc;
    expect_evt(d + 4, 4'b1100, '0, 4'b1100);
    repeat (8) step(1'b1, 1'b0, 4'b1100);
    chk("en_before_rst", KEY_EN, 4'b1100);
    #2 CLR_N = 1'b0;
    #1;
    chk("async_rst_key_en", KEY_EN, 0);
    chk("async_rst_any_en", ANY_EN, 0);
    repeat (3) @(posedge CLK);
    #1 CLR_N = 1'b1;
    d = cyc;
    expect_evt(d + 4, 4'b1100, '0, 4'b1100);
    repeat (3) step(1'b1, 1'b0, 4'b1100);
    chk("en_3_ce_after_rst", KEY_EN, 0);
    repeat (5) step(1'b1, 1'b0, 4'b1100);
    chk("en_after_repress", KEY_EN, 4'b1100);
    d = cyc;
    expect_evt(d + 4, '0, 4'b1100, '0);
    repeat (8) step(1'b1, 1'b0, '0);
    chk("en_final", KEY_EN, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
